// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse-train generator.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int PTG_CNT_W = 8;
  localparam int PTG_NUM_W = 8;

endpackage

// File: rtl/pulse_train_gen_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module pulse_train_gen_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator driven by a valid/ready command.
// Optional registered edge strobes are enabled with PTG_EDGE_STRB_EN.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = PTG_CNT_W,
  parameter int NUM_W = PTG_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_high,
  input  logic [CNT_W-1:0] cmd_low,
  input  logic [NUM_W-1:0] cmd_num,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
`ifdef PTG_EDGE_STRB_EN
  ,
  output logic             rise_strb,
  output logic             fall_strb
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             out_q, out_d;
  logic             done_q, done_d;

  logic             ph_load, ph_en, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             rem_load, rem_en, rem_zero;
  logic [NUM_W-1:0] rem_val;
  logic             handshake;

  function automatic logic [CNT_W-1:0] phaseReload(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign handshake = cmd_valid && cmd_ready;

  pulse_train_gen_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (ph_load),
    .val_i  (ph_val),
    .en_i   (ph_en),
    .zero_o (ph_zero)
  );

  pulse_train_gen_cnt #(.W(NUM_W)) u_remain_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (rem_load),
    .val_i  (rem_val),
    .en_i   (rem_en),
    .zero_o (rem_zero)
  );

  // The remaining count is consumed on entry to LOW, so a zero count at the
  // end of a low phase marks the final pulse of the train.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    ph_load  = 1'b0;
    ph_val   = '0;
    ph_en    = 1'b0;
    rem_load = 1'b0;
    rem_val  = '0;
    rem_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          hi_d     = phaseReload(cmd_high);
          lo_d     = phaseReload(cmd_low);
          ph_load  = 1'b1;
          ph_val   = phaseReload(cmd_high);
          rem_load = 1'b1;
          rem_val  = cmd_num;
          if (cmd_num == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          ph_load  = 1'b1;
          rem_load = 1'b1;
        end else if (ph_zero) begin
          state_d = LOW;
          ph_load = 1'b1;
          ph_val  = lo_q;
          rem_en  = 1'b1;
        end else begin
          ph_en = 1'b1;
        end
      end
      LOW: begin
        if (abort || (ph_zero && rem_zero)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          ph_load  = 1'b1;
          rem_load = 1'b1;
        end else if (ph_zero) begin
          state_d = HIGH;
          ph_load = 1'b1;
          ph_val  = hi_q;
        end else begin
          ph_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

`ifdef PTG_EDGE_STRB_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_strb = rise_q;
  assign fall_strb = fall_q;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen (strobe checks when
// PTG_EDGE_STRB_EN is defined).
module tb_pulse_train_gen;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_high;
  logic [7:0] cmd_low;
  logic [7:0] cmd_num;
  logic       abort;
  logic       out;
  logic       busy;
  logic       done;
`ifdef PTG_EDGE_STRB_EN
  logic       rise_strb;
  logic       fall_strb;
`endif

  int checks   = 0;
  int failures = 0;

  pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_high  (cmd_high),
    .cmd_low   (cmd_low),
    .cmd_num   (cmd_num),
    .abort     (abort),
    .out       (out),
    .busy      (busy),
    .done      (done)
`ifdef PTG_EDGE_STRB_EN
    ,
    .rise_strb (rise_strb),
    .fall_strb (fall_strb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] h, input logic [7:0] l,
                               input logic [7:0] n, input logic ab);
    cmd_valid = v;
    cmd_high  = h;
    cmd_low   = l;
    cmd_num   = n;
    abort     = ab;
  endtask

  task automatic checkOutput(input string tag, input logic eOut, input logic eBusy,
                             input logic eDone);
    checkBit({tag, ".out"}, out, eOut);
    checkBit({tag, ".busy"}, busy, eBusy);
    checkBit({tag, ".done"}, done, eDone);
  endtask

  task automatic checkStrb(input string tag, input logic eRise, input logic eFall);
`ifdef PTG_EDGE_STRB_EN
    checkBit({tag, ".rise"}, rise_strb, eRise);
    checkBit({tag, ".fall"}, fall_strb, eFall);
`else
    if (eRise && eFall) $display("[TB] %s impossible strobe pair", tag);
`endif
  endtask

  // pat bit i is the expected out level in cycle i+1 after the handshake.
  task automatic doTrain(input string name, input logic [7:0] h, input logic [7:0] l,
                         input logic [7:0] n, input logic ab, input logic [31:0] pat,
                         input int len);
    logic prev;
    prev = 1'b0;
    applyStimulus(1'b1, h, l, n, ab);
    #1;
    checkBit($sformatf("%s.c0.ready", name), cmd_ready, 1'b1);
    tick;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < len; i++) begin
      checkOutput($sformatf("%s.c%0d", name, i + 1), pat[i], 1'b1, 1'b0);
      checkStrb($sformatf("%s.c%0d", name, i + 1), pat[i] & ~prev, ~pat[i] & prev);
      prev = pat[i];
      tick;
    end
    checkOutput($sformatf("%s.c%0d", name, len + 1), 1'b0, 1'b0, 1'b1);
    checkStrb($sformatf("%s.c%0d", name, len + 1), 1'b0, prev);
    checkBit($sformatf("%s.c%0d.ready", name, len + 1), cmd_ready, 1'b1);
    tick;
    checkOutput($sformatf("%s.c%0d", name, len + 2), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick;
    tick;
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
    checkBit("reset.ready", cmd_ready, 1'b0);
    checkStrb("reset", 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("postreset.ready", cmd_ready, 1'b1);
    tick;

    $display("[TB] H=2 L=3 N=2");
    doTrain("h2l3n2", 8'd2, 8'd3, 8'd2, 1'b0, 32'b0001100011, 10);

    $display("[TB] H=0 L=0 N=3");
    doTrain("h0l0n3", 8'd0, 8'd0, 8'd3, 1'b0, 32'b010101, 6);

    $display("[TB] null command");
    doTrain("n0", 8'd5, 8'd5, 8'd0, 1'b0, 32'b0, 0);

    $display("[TB] abort with handshake in IDLE");
    doTrain("idleabort", 8'd1, 8'd1, 8'd1, 1'b1, 32'b01, 2);

    $display("[TB] abort in HIGH");
    applyStimulus(1'b1, 8'd4, 8'd4, 8'd5, 1'b0);
    tick;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("abort.c1", 1'b1, 1'b1, 1'b0);
    checkStrb("abort.c1", 1'b1, 1'b0);
    tick;
    tick;
    abort = 1'b1;
    checkOutput("abort.c3", 1'b1, 1'b1, 1'b0);
    tick;
    abort = 1'b0;
    checkOutput("abort.c4", 1'b0, 1'b0, 1'b1);
    checkStrb("abort.c4", 1'b0, 1'b1);
    tick;
    checkOutput("abort.c5", 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back command held while busy");
    applyStimulus(1'b1, 8'd1, 8'd1, 8'd2, 1'b0);
    tick;
    applyStimulus(1'b1, 8'd3, 8'd1, 8'd1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("b2b.c%0d", i), (i % 2) == 1, 1'b1, 1'b0);
      checkBit($sformatf("b2b.c%0d.ready", i), cmd_ready, 1'b0);
      tick;
    end
    checkOutput("b2b.c5", 1'b0, 1'b0, 1'b1);
    checkBit("b2b.c5.ready", cmd_ready, 1'b1);
    tick;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 6; i <= 9; i++) begin
      checkOutput($sformatf("b2b.c%0d", i), i <= 8, 1'b1, 1'b0);
      tick;
    end
    checkOutput("b2b.c10", 1'b0, 1'b0, 1'b1);
    tick;
    checkOutput("b2b.c11", 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during LOW");
    applyStimulus(1'b1, 8'd1, 8'd2, 8'd3, 1'b0);
    tick;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("rstlow.c1", 1'b1, 1'b1, 1'b0);
    tick;
    checkOutput("rstlow.c2", 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick;
    checkOutput("rstlow.c3", 1'b0, 1'b0, 1'b0);
    checkBit("rstlow.c3.ready", cmd_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("rstlow.c3.readyafter", cmd_ready, 1'b1);
    tick;
    checkOutput("rstlow.c4", 1'b0, 1'b0, 1'b0);
    tick;
    checkOutput("rstlow.c5", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
